// File: rtl/alu_reservation_station.sv
// Reservation station in front of the ALU: buffers dispatched ops and wakes operands from both CDBs.
// Latency: an op ready at dispatch issues one edge after it is written; a woken op one edge after wakeup.
// Backpressure: full_o asserts with one slot still free to cover in-flight dispatch; en low freezes all state.
module alu_reservation_station #(
    parameter int RS_BIT  = 3,
    parameter int ROB_BIT = 4,
    parameter int OP_W    = 6,
    parameter int DAT_W   = 32,
    parameter int ADR_W   = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               flush_i,
    input  logic               dec_en_i,
    input  logic [OP_W-1:0]    dec_op_i,
    input  logic               dec_ic_i,
    input  logic [ROB_BIT-1:0] dec_qd_i,
    input  logic [DAT_W-1:0]   dec_imm_i,
    input  logic [ADR_W-1:0]   dec_pc_i,
    input  logic               dec_rs_ok_i,
    input  logic [ROB_BIT-1:0] dec_qs_i,
    input  logic [DAT_W-1:0]   dec_vs_i,
    input  logic               dec_rt_ok_i,
    input  logic [ROB_BIT-1:0] dec_qt_i,
    input  logic [DAT_W-1:0]   dec_vt_i,
    output logic               full_o,
    input  logic               cdb_alu_en_i,
    input  logic [ROB_BIT-1:0] cdb_alu_q_i,
    input  logic [DAT_W-1:0]   cdb_alu_v_i,
    input  logic               cdb_lsb_en_i,
    input  logic [ROB_BIT-1:0] cdb_lsb_q_i,
    input  logic [DAT_W-1:0]   cdb_lsb_v_i,
    output logic               alu_en_o,
    output logic [OP_W-1:0]    alu_op_o,
    output logic               alu_ic_o,
    output logic [ROB_BIT-1:0] alu_qd_o,
    output logic [DAT_W-1:0]   alu_vs_o,
    output logic [DAT_W-1:0]   alu_vt_o,
    output logic [DAT_W-1:0]   alu_imm_o,
    output logic [ADR_W-1:0]   alu_pc_o
);
    localparam int RS_SIZE = 1 << RS_BIT;
    localparam int CNT_W   = RS_BIT + 1;

    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] rs_ok;
    logic [RS_SIZE-1:0] rt_ok;
    logic [RS_SIZE-1:0] e_ic;
    logic [OP_W-1:0]    e_op  [RS_SIZE];
    logic [ROB_BIT-1:0] e_qd  [RS_SIZE];
    logic [ROB_BIT-1:0] e_qs  [RS_SIZE];
    logic [ROB_BIT-1:0] e_qt  [RS_SIZE];
    logic [DAT_W-1:0]   e_imm [RS_SIZE];
    logic [DAT_W-1:0]   e_vs  [RS_SIZE];
    logic [DAT_W-1:0]   e_vt  [RS_SIZE];
    logic [ADR_W-1:0]   e_pc  [RS_SIZE];
    logic [CNT_W-1:0]   count;

    logic               free_found;
    logic               iss_found;
    logic [RS_BIT-1:0]  free_idx;
    logic [RS_BIT-1:0]  iss_idx;
    logic               do_disp;
    logic               do_iss;
    logic               disp_rs_ok;
    logic               disp_rt_ok;
    logic [DAT_W-1:0]   disp_vs;
    logic [DAT_W-1:0]   disp_vt;

    assign full_o  = (count >= CNT_W'(RS_SIZE - 1));
    assign do_disp = en & ~flush_i & dec_en_i & free_found;
    assign do_iss  = en & ~flush_i & iss_found;

    // Lowest free slot and lowest issuable slot, both from pre-edge state
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        iss_found  = 1'b0;
        iss_idx    = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_found = 1'b1;
                free_idx   = RS_BIT'(i);
            end
            if (busy[i] && rs_ok[i] && rt_ok[i]) begin
                iss_found = 1'b1;
                iss_idx   = RS_BIT'(i);
            end
        end
    end

    // Dispatched operands that are still pending may be satisfied by a same-cycle broadcast
    always_comb begin
        disp_rs_ok = dec_rs_ok_i;
        disp_vs    = dec_vs_i;
        disp_rt_ok = dec_rt_ok_i;
        disp_vt    = dec_vt_i;
        if (!dec_rs_ok_i) begin
            if (cdb_alu_en_i && cdb_alu_q_i == dec_qs_i) begin
                disp_rs_ok = 1'b1;
                disp_vs    = cdb_alu_v_i;
            end else if (cdb_lsb_en_i && cdb_lsb_q_i == dec_qs_i) begin
                disp_rs_ok = 1'b1;
                disp_vs    = cdb_lsb_v_i;
            end
        end
        if (!dec_rt_ok_i) begin
            if (cdb_alu_en_i && cdb_alu_q_i == dec_qt_i) begin
                disp_rt_ok = 1'b1;
                disp_vt    = cdb_alu_v_i;
            end else if (cdb_lsb_en_i && cdb_lsb_q_i == dec_qt_i) begin
                disp_rt_ok = 1'b1;
                disp_vt    = cdb_lsb_v_i;
            end
        end
    end

    // Occupancy, busy bits and the registered issue port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= '0;
            count     <= '0;
            alu_en_o  <= 1'b0;
            alu_op_o  <= '0;
            alu_ic_o  <= 1'b0;
            alu_qd_o  <= '0;
            alu_vs_o  <= '0;
            alu_vt_o  <= '0;
            alu_imm_o <= '0;
            alu_pc_o  <= '0;
        end else if (en) begin
            if (flush_i) begin
                busy     <= '0;
                count    <= '0;
                alu_en_o <= 1'b0;
            end else begin
                alu_en_o <= do_iss;
                if (do_iss) begin
                    busy[iss_idx] <= 1'b0;
                    alu_op_o      <= e_op[iss_idx];
                    alu_ic_o      <= e_ic[iss_idx];
                    alu_qd_o      <= e_qd[iss_idx];
                    alu_vs_o      <= e_vs[iss_idx];
                    alu_vt_o      <= e_vt[iss_idx];
                    alu_imm_o     <= e_imm[iss_idx];
                    alu_pc_o      <= e_pc[iss_idx];
                end
                // The free slot is never the issuing one, so both writes can coexist
                if (do_disp) begin
                    busy[free_idx] <= 1'b1;
                end
                count <= count + CNT_W'(do_disp) - CNT_W'(do_iss);
            end
        end
    end

    // Entry payload: CDB wakeup of waiting operands plus the dispatch write
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i] && !rs_ok[i]) begin
                    if (cdb_alu_en_i && cdb_alu_q_i == e_qs[i]) begin
                        rs_ok[i] <= 1'b1;
                        e_vs[i]  <= cdb_alu_v_i;
                    end else if (cdb_lsb_en_i && cdb_lsb_q_i == e_qs[i]) begin
                        rs_ok[i] <= 1'b1;
                        e_vs[i]  <= cdb_lsb_v_i;
                    end
                end
                if (busy[i] && !rt_ok[i]) begin
                    if (cdb_alu_en_i && cdb_alu_q_i == e_qt[i]) begin
                        rt_ok[i] <= 1'b1;
                        e_vt[i]  <= cdb_alu_v_i;
                    end else if (cdb_lsb_en_i && cdb_lsb_q_i == e_qt[i]) begin
                        rt_ok[i] <= 1'b1;
                        e_vt[i]  <= cdb_lsb_v_i;
                    end
                end
            end
            if (do_disp) begin
                e_op[free_idx]  <= dec_op_i;
                e_ic[free_idx]  <= dec_ic_i;
                e_qd[free_idx]  <= dec_qd_i;
                e_imm[free_idx] <= dec_imm_i;
                e_pc[free_idx]  <= dec_pc_i;
                e_qs[free_idx]  <= dec_qs_i;
                e_qt[free_idx]  <= dec_qt_i;
                rs_ok[free_idx] <= disp_rs_ok;
                e_vs[free_idx]  <= disp_vs;
                rt_ok[free_idx] <= disp_rt_ok;
                e_vt[free_idx]  <= disp_vt;
            end
        end
    end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed scenarios then random traffic.
// Latency: reference model steps once per rising edge and predicts the issue port one edge later.
// Backpressure: dispatch is only driven while the model shows a free slot beyond the headroom slot.
module tb_alu_reservation_station;
    localparam int RS_SIZE = 8;

    logic        clk = 1'b0;
    logic        rst, en, flush_i, dec_en_i, dec_ic_i;
    logic [5:0]  dec_op_i;
    logic [3:0]  dec_qd_i, dec_qs_i, dec_qt_i;
    logic [31:0] dec_imm_i, dec_vs_i, dec_vt_i;
    logic [16:0] dec_pc_i;
    logic        dec_rs_ok_i, dec_rt_ok_i, full_o;
    logic        cdb_alu_en_i, cdb_lsb_en_i;
    logic [3:0]  cdb_alu_q_i, cdb_lsb_q_i;
    logic [31:0] cdb_alu_v_i, cdb_lsb_v_i;
    logic        alu_en_o, alu_ic_o;
    logic [5:0]  alu_op_o;
    logic [3:0]  alu_qd_o;
    logic [31:0] alu_vs_o, alu_vt_o, alu_imm_o;
    logic [16:0] alu_pc_o;

    always #5 clk = ~clk;

    alu_reservation_station dut (
        .clk(clk), .rst(rst), .en(en), .flush_i(flush_i),
        .dec_en_i(dec_en_i), .dec_op_i(dec_op_i), .dec_ic_i(dec_ic_i), .dec_qd_i(dec_qd_i),
        .dec_imm_i(dec_imm_i), .dec_pc_i(dec_pc_i),
        .dec_rs_ok_i(dec_rs_ok_i), .dec_qs_i(dec_qs_i), .dec_vs_i(dec_vs_i),
        .dec_rt_ok_i(dec_rt_ok_i), .dec_qt_i(dec_qt_i), .dec_vt_i(dec_vt_i),
        .full_o(full_o),
        .cdb_alu_en_i(cdb_alu_en_i), .cdb_alu_q_i(cdb_alu_q_i), .cdb_alu_v_i(cdb_alu_v_i),
        .cdb_lsb_en_i(cdb_lsb_en_i), .cdb_lsb_q_i(cdb_lsb_q_i), .cdb_lsb_v_i(cdb_lsb_v_i),
        .alu_en_o(alu_en_o), .alu_op_o(alu_op_o), .alu_ic_o(alu_ic_o), .alu_qd_o(alu_qd_o),
        .alu_vs_o(alu_vs_o), .alu_vt_o(alu_vt_o), .alu_imm_o(alu_imm_o), .alu_pc_o(alu_pc_o)
    );

    typedef struct {
        bit busy; bit [5:0] op; bit ic; bit [3:0] qd; bit [31:0] imm; bit [16:0] pc;
        bit rs_ok; bit [3:0] qs; bit [31:0] vs; bit rt_ok; bit [3:0] qt; bit [31:0] vt;
    } ent_t;
    typedef struct packed {
        logic [5:0] op; logic ic; logic [3:0] qd; logic [31:0] vs; logic [31:0] vt;
        logic [31:0] imm; logic [16:0] pc;
    } iss_t;

    ent_t m [RS_SIZE];
    iss_t exp_q [$];
    bit   m_en;
    bit   edge_en;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        foreach (m[i]) if (m[i].busy) c++;
        return c;
    endfunction

    // Operand value after looking at this cycle's broadcasts; ALU CDB wins a tie
    function automatic bit [32:0] resolve(input bit ok, input bit [3:0] q, input bit [31:0] v);
        if (ok) return {1'b1, v};
        if (cdb_alu_en_i && cdb_alu_q_i == q) return {1'b1, cdb_alu_v_i};
        if (cdb_lsb_en_i && cdb_lsb_q_i == q) return {1'b1, cdb_lsb_v_i};
        return {1'b0, v};
    endfunction

    task automatic model_reset();
        foreach (m[i]) m[i].busy = 1'b0;
        m_en = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step();
        ent_t nx [RS_SIZE];
        int iss, free;
        bit [32:0] r;
        iss_t e;
        if (!en) return;
        if (flush_i) begin
            foreach (m[i]) m[i].busy = 1'b0;
            m_en = 1'b0;
            return;
        end
        iss = -1;
        free = -1;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (iss < 0 && m[i].busy && m[i].rs_ok && m[i].rt_ok) iss = i;
            if (free < 0 && !m[i].busy) free = i;
        end
        nx = m;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (nx[i].busy) begin
                r = resolve(nx[i].rs_ok, nx[i].qs, nx[i].vs);
                nx[i].rs_ok = r[32]; nx[i].vs = r[31:0];
                r = resolve(nx[i].rt_ok, nx[i].qt, nx[i].vt);
                nx[i].rt_ok = r[32]; nx[i].vt = r[31:0];
            end
        end
        if (iss >= 0) begin
            e.op = m[iss].op; e.ic = m[iss].ic; e.qd = m[iss].qd; e.vs = m[iss].vs;
            e.vt = m[iss].vt; e.imm = m[iss].imm; e.pc = m[iss].pc;
            exp_q.push_back(e);
            nx[iss].busy = 1'b0;
            m_en = 1'b1;
        end else begin
            m_en = 1'b0;
        end
        if (dec_en_i) begin
            check("dispatch_has_free_slot", (free >= 0), 1);
            if (free >= 0) begin
                nx[free].busy = 1'b1; nx[free].op = dec_op_i; nx[free].ic = dec_ic_i;
                nx[free].qd = dec_qd_i; nx[free].imm = dec_imm_i; nx[free].pc = dec_pc_i;
                nx[free].qs = dec_qs_i; nx[free].qt = dec_qt_i;
                r = resolve(dec_rs_ok_i, dec_qs_i, dec_vs_i);
                nx[free].rs_ok = r[32]; nx[free].vs = r[31:0];
                r = resolve(dec_rt_ok_i, dec_qt_i, dec_vt_i);
                nx[free].rt_ok = r[32]; nx[free].vt = r[31:0];
            end
        end
        m = nx;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        dec_en_i = 0; cdb_alu_en_i = 0; cdb_lsb_en_i = 0; flush_i = 0;
    endtask

    task automatic disp(input bit [5:0] op, input bit [3:0] qd, input bit rs_ok, input bit [3:0] qs,
                        input bit [31:0] vs, input bit rt_ok, input bit [3:0] qt, input bit [31:0] vt,
                        input bit [31:0] imm);
        dec_en_i = 1; dec_op_i = op; dec_ic_i = op[0]; dec_qd_i = qd; dec_imm_i = imm;
        dec_pc_i = 17'($urandom); dec_rs_ok_i = rs_ok; dec_qs_i = qs; dec_vs_i = vs;
        dec_rt_ok_i = rt_ok; dec_qt_i = qt; dec_vt_i = vt;
    endtask

    task automatic cdb_alu(input bit [3:0] q, input bit [31:0] v);
        cdb_alu_en_i = 1; cdb_alu_q_i = q; cdb_alu_v_i = v;
    endtask

    task automatic cdb_lsb(input bit [3:0] q, input bit [31:0] v);
        cdb_lsb_en_i = 1; cdb_lsb_q_i = q; cdb_lsb_v_i = v;
    endtask

    // Monitor: issue handshake and occupancy flag against the model, payload from the scoreboard
    always @(posedge clk) edge_en <= en;

    always @(negedge clk) begin
        iss_t got;
        if (!rst) begin
            check("alu_en_o", alu_en_o, m_en);
            check("full_o", full_o, (m_count() >= RS_SIZE - 1));
            if (alu_en_o && edge_en) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_issue: got qd=%0h expected no issue at %0t", alu_qd_o, $time);
                end else begin
                    n_chk--;
                    got.op = alu_op_o; got.ic = alu_ic_o; got.qd = alu_qd_o; got.vs = alu_vs_o;
                    got.vt = alu_vt_o; got.imm = alu_imm_o; got.pc = alu_pc_o;
                    check("issue_record", got, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1; en = 1; idle();
        dec_op_i = 0; dec_ic_i = 0; dec_qd_i = 0; dec_imm_i = 0; dec_pc_i = 0;
        dec_rs_ok_i = 0; dec_qs_i = 0; dec_vs_i = 0; dec_rt_ok_i = 0; dec_qt_i = 0; dec_vt_i = 0;
        cdb_alu_q_i = 0; cdb_alu_v_i = 0; cdb_lsb_q_i = 0; cdb_lsb_v_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_alu_en", alu_en_o, 0);
        check("rst_full", full_o, 0);
        check("rst_qd", alu_qd_o, 0);
        check("rst_vs", alu_vs_o, 0);
        rst = 0;

        // ADDI ready at dispatch: one-cycle issue pulse
        disp(6'h13, 4'd2, 1, 4'd0, 32'd5, 1, 4'd0, 32'd0, 32'd3); tick(); idle(); tick();
        check("t1_en", alu_en_o, 1);
        check("t1_qd", alu_qd_o, 2);
        check("t1_vs", alu_vs_o, 5);
        check("t1_imm", alu_imm_o, 3);
        tick();
        check("t1_pulse_low", alu_en_o, 0);

        // Waiting src1 woken by ALU CDB
        disp(6'h01, 4'd3, 0, 4'd4, 32'd0, 1, 4'd0, 32'd1, 32'd0); tick(); idle();
        tick(); tick();
        cdb_alu(4'd4, 32'h10); tick(); idle();
        check("t2_no_bypass", alu_en_o, 0);
        tick();
        check("t2_en", alu_en_o, 1);
        check("t2_vs", alu_vs_o, 32'h10);
        check("t2_vt", alu_vt_o, 1);
        tick();

        // Same-cycle LSB broadcast captured at dispatch
        disp(6'h02, 4'd5, 1, 4'd0, 32'd9, 0, 4'd7, 32'd0, 32'd0);
        cdb_lsb(4'd7, 32'hABCD); tick(); idle(); tick();
        check("t3_en", alu_en_o, 1);
        check("t3_vt", alu_vt_o, 32'hABCD);
        tick();

        // Fill to the headroom slot, then free one
        for (int i = 1; i <= 7; i++) begin
            disp(6'h04, 4'(i), 0, 4'(i), 32'd0, 1, 4'd0, 32'(i), 32'(i)); tick();
        end
        idle();
        check("t4_full", full_o, 1);
        cdb_alu(4'd3, 32'h33); tick(); idle();
        check("t4_full_after_wake", full_o, 1);
        tick();
        check("t4_issue", alu_en_o, 1);
        check("t4_not_full", full_o, 0);
        for (int t = 1; t <= 7; t++) begin
            if (t != 3) begin cdb_lsb(4'(t), 32'(t * 16)); tick(); end
        end
        idle(); repeat (3) tick();

        // Lowest index first, flush kills the second issue
        for (int k = 0; k < 4; k++) begin
            disp(6'h05, 4'(k + 8), 0, 4'(k + 8), 32'd0, 1, 4'd0, 32'd0, 32'd0); tick();
        end
        idle(); cdb_alu(4'd9, 32'h99); cdb_lsb(4'd11, 32'hBB); tick(); idle(); tick();
        check("t5_first_qd", alu_qd_o, 9);
        flush_i = 1; tick(); flush_i = 0;
        check("t5_flush_en", alu_en_o, 0);
        cdb_alu(4'd8, 32'h1); cdb_lsb(4'd10, 32'h2); tick(); idle(); tick();
        check("t5_no_issue", alu_en_o, 0);

        // Asynchronous reset mid-cycle with issue pulse and full flag both high
        for (int k = 1; k <= 6; k++) begin
            disp(6'h06, 4'(k), 0, 4'(k), 32'd0, 1, 4'd0, 32'd0, 32'd0); tick();
        end
        disp(6'h07, 4'd15, 1, 4'd0, 32'd1, 1, 4'd0, 32'd2, 32'd0); tick();
        disp(6'h06, 4'd7, 0, 4'd7, 32'd0, 1, 4'd0, 32'd0, 32'd0); tick(); idle();
        check("t6_pre_en", alu_en_o, 1);
        check("t6_pre_full", full_o, 1);
        #2; rst = 1; model_reset(); #1;
        check("t6_async_en", alu_en_o, 0);
        check("t6_async_full", full_o, 0);
        @(posedge clk); #1; rst = 0;
        for (int t = 1; t <= 7; t++) begin cdb_alu(4'(t), 32'(t)); tick(); end
        idle(); repeat (2) tick();
        check("t6_stale_tags", alu_en_o, 0);

        // en low freezes a ready entry
        disp(6'h08, 4'd6, 0, 4'd2, 32'd0, 1, 4'd0, 32'd5, 32'd0); tick(); idle();
        cdb_alu(4'd2, 32'h77); tick(); idle();
        en = 0;
        disp(6'h09, 4'd1, 1, 4'd0, 32'd1, 1, 4'd0, 32'd1, 32'd0); cdb_lsb(4'd0, 32'h5);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("t6_en_low_hold", alu_en_o, 0);
        end
        idle(); en = 1; tick();
        check("t6_resume_en", alu_en_o, 1);
        check("t6_resume_vs", alu_vs_o, 32'h77);
        tick();

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            idle();
            en = ($urandom_range(0, 9) != 0);
            flush_i = ($urandom_range(0, 49) == 0);
            if (m_count() < RS_SIZE - 1 && $urandom_range(0, 2) != 0)
                disp(6'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), $urandom,
                     1'($urandom), 4'($urandom), $urandom, $urandom);
            if ($urandom_range(0, 2) == 0) cdb_alu(4'($urandom), $urandom);
            if ($urandom_range(0, 2) == 0) cdb_lsb(4'($urandom), $urandom);
            tick();
        end
        idle(); en = 1;
        for (int t = 0; t < 48; t++) begin
            cdb_alu(4'(t), $urandom); cdb_lsb(4'(t + 8), $urandom); tick();
        end
        idle(); repeat (4) tick();
        check("drain_model_empty", m_count(), 0);
        check("drain_scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
